halflife_decay_gen: RTL and testbench

//  Upstream stimulus stage for the half-life population counter.
//  - Seeds the counter with an initial population.
//  - Issues pseudo-random single-cycle decrement pulses, one trial per prescaled epoch.
//  - Flags the epoch at which the population first falls to half the seed.
//  - Signals done when the population reaches zero.

---
 rtl/halflife_pkg.sv | 19 +
 rtl/halflife_lfsr.sv | 36 +++
 rtl/halflife_decay_gen.sv | 148 ++++++++++++++
 tb/tb_halflife_decay_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/halflife_pkg.sv
// Shared definitions for the half-life decay stimulus generator.
//   state_t    : controller states IDLE / LOAD / RUN / DONE
//   LFSR_SEED  : LFSR value after reset (never zero)
//   LFSR_MASK  : Galois feedback mask for the 16-bit LFSR
//   PROB_W     : width of the decay probability threshold
package halflife_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          PROB_W    = 8;

endpackage

// File: rtl/halflife_lfsr.sv
// Galois LFSR used as the random source for decay trials.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, loads LFSR_SEED
//   en     : advance one step this cycle
//   rnd    : low OUT_W bits of the value the LFSR takes after this step
//            (the look-ahead value, so a trial can use the fresh draw in
//            the same cycle the step happens)
module halflife_lfsr
  import halflife_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;

  // Right-shifting Galois form: the bit shifted out folds back through the mask.
  assign lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]}
                   ^ (lfsr_q[0] ? LFSR_W'(LFSR_MASK) : '0);
  assign rnd       = lfsr_next[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_W'(LFSR_SEED);
    end else if (en) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/halflife_decay_gen.sv
// Stimulus generator for the half-life population counter.
// Seeds the counter, then once per prescaled epoch runs a random decay trial
// and issues a single-cycle decrement pulse on success. Finishes when the
// fed-back population reaches zero.
//   clk, rst     : clock / synchronous active-high reset
//   start, stop  : level controls; stop has priority
//   seed         : initial population, captured when a run starts
//   prob         : per-epoch decay probability = prob/256
//   div          : epoch period = div+1 cycles
//   pop_in       : live counter value
//   cnt_load     : one-cycle load pulse, cnt_in holds the captured seed
//   cnt_down     : one-cycle decrement pulse
//   busy / done  : in LOAD-RUN / in DONE
//   half_mark    : pulses on the first RUN cycle with pop_in <= seed>>1
//   half_epochs  : epochs elapsed when half_mark fired
// Build option: define HALFLIFE_MARK_EN to include the half-life detector;
// without it half_mark and half_epochs are constant 0.
module halflife_decay_gen
  import halflife_pkg::*;
#(
  parameter int N      = 4,
  parameter int PRE_W  = 16,
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [N-1:0]      seed,
  input  logic [PROB_W-1:0] prob,
  input  logic [PRE_W-1:0]  div,
  input  logic [N-1:0]      pop_in,
  output logic              cnt_load,
  output logic [N-1:0]      cnt_in,
  output logic              cnt_down,
  output logic              busy,
  output logic              done,
  output logic              half_mark,
  output logic [PRE_W-1:0]  half_epochs
);

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  presc_q;
  logic [N-1:0]      seed_q;
  logic              cnt_down_q;
  logic              strobe;
  logic              trial;
  logic [PROB_W-1:0] rnd;

  assign strobe = (state_q == RUN) && (presc_q == div);

  // The counter sees cnt_down one cycle late, so a pending pulse with
  // pop_in==1 already accounts for the last unit; block a further trial.
  assign trial = strobe && (rnd < prob) && (pop_in != '0)
              && !(cnt_down_q && (pop_in == N'(1)));

  halflife_lfsr #(
    .LFSR_W (LFSR_W),
    .OUT_W  (PROB_W)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (strobe),
    .rnd (rnd)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && (seed != '0)) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if ((pop_in == '0) && !cnt_down_q) state_d = DONE;
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      seed_q     <= '0;
      cnt_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_down_q <= trial && !stop;
      if ((state_d == LOAD) && (state_q != LOAD)) begin
        seed_q <= seed;
      end
      if (state_q == LOAD) begin
        presc_q <= '0;
      end else if (state_q == RUN) begin
        presc_q <= strobe ? '0 : presc_q + 1'b1;
      end
    end
  end

  assign cnt_load = (state_q == LOAD);
  assign cnt_in   = seed_q;
  assign cnt_down = cnt_down_q;
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = (state_q == DONE);

`ifdef HALFLIFE_MARK_EN
  logic [N-1:0]     half_thr_q;
  logic [PRE_W-1:0] epoch_q;
  logic [PRE_W-1:0] half_ep_q;
  logic             half_seen_q;
  logic             half_hit;

  assign half_hit = (state_q == RUN) && !half_seen_q && (pop_in <= half_thr_q);

  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      half_thr_q <= seed_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q     <= '0;
      half_ep_q   <= '0;
      half_seen_q <= 1'b0;
    end else if (state_q == LOAD) begin
      epoch_q     <= '0;
      half_ep_q   <= '0;
      half_seen_q <= 1'b0;
    end else if (state_q == RUN) begin
      // Saturating: the all-ones value means "at least this many epochs".
      if (strobe && (epoch_q != '1)) begin
        epoch_q <= epoch_q + 1'b1;
      end
      if (half_hit) begin
        half_seen_q <= 1'b1;
        half_ep_q   <= epoch_q;
      end
    end
  end

  assign half_mark   = half_hit;
  assign half_epochs = half_ep_q;
`else
  assign half_mark   = 1'b0;
  assign half_epochs = '0;
`endif

endmodule

// File: tb/tb_halflife_decay_gen.sv
// Directed bench for halflife_decay_gen with a behavioural population
// counter on the feedback path. Expectations for the optional half-life
// detector follow HALFLIFE_MARK_EN as defined for the build.
module tb_halflife_decay_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  seed = 4'd0;
  logic [7:0]  prob = 8'd0;
  logic [15:0] div = 16'd0;
  logic [3:0]  tb_pop;
  logic        cnt_load, cnt_down, busy, done, half_mark;
  logic [3:0]  cnt_in;
  logic [15:0] half_epochs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  halflife_decay_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .seed        (seed),
    .prob        (prob),
    .div         (div),
    .pop_in      (tb_pop),
    .cnt_load    (cnt_load),
    .cnt_in      (cnt_in),
    .cnt_down    (cnt_down),
    .busy        (busy),
    .done        (done),
    .half_mark   (half_mark),
    .half_epochs (half_epochs)
  );

  // Population counter model driven by the DUT pulses (wraps on underflow
  // so an illegal decrement would be visible).
  always_ff @(posedge clk) begin
    if (rst)           tb_pop <= 4'd0;
    else if (cnt_load) tb_pop <= cnt_in;
    else if (cnt_down) tb_pop <= tb_pop - 4'd1;
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ndown, nbusy_low, nload, nunder, nhalf, k, k_half;
    logic [3:0]  pop_half;
    logic        got_done, exp_down, exp_next, dec;
    logic [15:0] mlfsr;

    // 1. reset
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cnt_load", 32'(cnt_load), 32'd0);
    chk("rst_cnt_in", 32'(cnt_in), 32'd0);
    chk("rst_cnt_down", 32'(cnt_down), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_half_mark", 32'(half_mark), 32'd0);
    chk("rst_half_epochs", 32'(half_epochs), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
    chk("rst_state", 32'(dut.state_q), 32'd0);

    // 2. prob=0: load once, never decrement
    seed = 4'd8; prob = 8'd0; div = 16'd3; start = 1'b1;
    tick();
    chk("t2_cnt_load", 32'(cnt_load), 32'd1);
    chk("t2_cnt_in", 32'(cnt_in), 32'd8);
    chk("t2_busy_load", 32'(busy), 32'd1);
    start = 1'b0;
    ndown = 0; nbusy_low = 0; nload = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (cnt_down) ndown++;
      if (!busy) nbusy_low++;
      if (cnt_load) nload++;
    end
    chk("t2_no_down", 32'(ndown), 32'd0);
    chk("t2_busy_held", 32'(nbusy_low), 32'd0);
    chk("t2_single_load", 32'(nload), 32'd0);
    chk("t2_pop_held", 32'(tb_pop), 32'd8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_busy", 32'(busy), 32'd0);
    chk("t2_stop_down", 32'(cnt_down), 32'd0);

    // 3. prob=255, div=0: full decay to zero
    seed = 4'd15; prob = 8'd255; div = 16'd0; start = 1'b1;
    tick();
    chk("t3_cnt_in", 32'(cnt_in), 32'd15);
    start = 1'b0;
    ndown = 0; nunder = 0; nhalf = 0; k = 0; k_half = -1; pop_half = 4'd0; got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      tick();
      if (cnt_down) ndown++;
      if (cnt_down && tb_pop == 4'd0) nunder++;
      if (done) got_done = 1'b1;
      else begin
        if (half_mark) begin
          nhalf++;
          pop_half = tb_pop;
          k_half = k;
        end
        k++;
      end
    end
    chk("t3_done", 32'(got_done), 32'd1);
    chk("t3_down_count", 32'(ndown), 32'd15);
    chk("t3_no_underflow", 32'(nunder), 32'd0);
    chk("t3_pop_zero", 32'(tb_pop), 32'd0);
`ifdef HALFLIFE_MARK_EN
    chk("t3_half_once", 32'(nhalf), 32'd1);
    chk("t3_half_pop", 32'(pop_half), 32'd7);
    chk("t3_half_epochs", 32'(half_epochs), 32'(k_half));
`else
    chk("t3_half_none", 32'(nhalf), 32'd0);
    chk("t3_half_epochs_zero", 32'(half_epochs), 32'd0);
`endif
    ndown = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cnt_down) ndown++;
    end
    chk("t3_done_quiet", 32'(ndown), 32'd0);
    chk("t3_done_held", 32'(done), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_done", 32'(done), 32'd0);

    // 4. div=4, prob=128: cycle-exact pulse sequence against a model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mlfsr = 16'hACE1;
    seed = 4'd15; prob = 8'd128; div = 16'd4; start = 1'b1;
    tick();
    chk("t4_load_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(mlfsr));
    start = 1'b0;
    exp_down = 1'b0;
    for (int kk = 0; kk <= 60; kk++) begin
      tick();
      chk("t4_cnt_down", 32'(cnt_down), 32'(exp_down));
      chk("t4_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(mlfsr));
      exp_next = 1'b0;
      if (kk % 5 == 4) begin
        mlfsr = ref_step(mlfsr);
        dec = (mlfsr[7:0] < prob) && (tb_pop != 4'd0) && !(exp_down && tb_pop == 4'd1);
        exp_next = dec;
      end
      exp_down = exp_next;
    end

    // 5. stop handling (RUN cycle 60 is not an epoch strobe)
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_run_stop_busy", 32'(busy), 32'd0);
    chk("t5_run_stop_down", 32'(cnt_down), 32'd0);
    ndown = 0; nbusy_low = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cnt_down) ndown++;
      if (busy) nbusy_low++;
    end
    chk("t5_idle_quiet", 32'(ndown), 32'd0);
    chk("t5_idle_not_busy", 32'(nbusy_low), 32'd0);
    chk("t5_lfsr_kept", 32'(dut.u_lfsr.lfsr_q), 32'(mlfsr));
    start = 1'b1; stop = 1'b1;
    tick();
    chk("t5_startstop_busy", 32'(busy), 32'd0);
    chk("t5_startstop_load", 32'(cnt_load), 32'd0);
    stop = 1'b0;
    tick();
    chk("t5_load_enter", 32'(cnt_load), 32'd1);
    stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_load_stop_busy", 32'(busy), 32'd0);
    chk("t5_load_stop_load", 32'(cnt_load), 32'd0);
    seed = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_seed0_ignored", 32'(busy), 32'd0);
    chk("t5_lfsr_frozen", 32'(dut.u_lfsr.lfsr_q), 32'(mlfsr));

    // rst mid-run
    seed = 4'd15; prob = 8'd255; div = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t6_running", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_down", 32'(cnt_down), 32'd0);
    chk("t6_rst_cnt_in", 32'(cnt_in), 32'd0);
    chk("t6_rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
